wm_cycle_sequencer: RTL
=======================

Name: wm_cycle_sequencer

Overview:
Command-side initiator for the wash actuator interface. It drives ctrl[2:0] and data[7:0] and consumes data_out[7:0] and status[7:0] from the actuator block. On a start request it steps through a hard-wired wash program (fill/wash/drain/rinse/spin). Each step is held on the bus until the actuator reports done, an error occurs, or a timeout expires. It sits between the front-panel logic and the actuator block.

Parameters:
TIMEOUT_CYC, 1000, max RUN cycles per step (unpaused) before timeout fault; must be >= 2
TO_W, 16, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin program; sampled only in IDLE
prog_sel  input  2  program select, latched with start
pause  input  1  level: suspend current step while high
clr_fault  input  1  clears FAULT state back to IDLE
rsp_data  input  8  actuator data_out
rsp_status  input  8  actuator status; bit0 = step done, bit7 = error, others ignored
cmd_ctrl  output  3  actuator ctrl code
cmd_data  output  8  actuator data_in (step parameter)
busy  output  1  high in any state except IDLE and FAULT
done  output  1  one-cycle pulse on program completion
fault  output  1  high while in FAULT
fault_code  output  2  0 none, 1 actuator error, 2 timeout
step_idx  output  3  index of current step within program
last_rsp  output  8  rsp_data captured at last step completion

Behaviour:
- Ctrl codes: 0 NOP, 1 FILL, 2 WASH, 3 DRAIN, 4 RINSE, 5 SPIN, 6 STOP, 7 PAUSE.
- Program table, as (ctrl,data) per step; DRAIN data = 8'h00:
  - prog 0: FILL 40h, WASH 05h, DRAIN, SPIN 80h.
  - prog 1: FILL 80h, WASH 0Fh, DRAIN, RINSE 80h, DRAIN, SPIN C0h.
  - prog 2: FILL FFh, WASH 1Eh, DRAIN, RINSE FFh, DRAIN, SPIN FFh.
  - prog 3: RINSE 80h, DRAIN, SPIN C0h.
- Reset values: cmd_ctrl=0, cmd_data=0, busy=0, done=0, fault=0, fault_code=0, step_idx=0, last_rsp=0; state IDLE; timeout counter 0.
- States: IDLE, RUN, GAP, ABORT, FAULT.
- IDLE:
  - Outputs ctrl/data = 0.
  - start=1 latches prog_sel, sets step_idx=0, enters RUN.
  - Step 0 ctrl/data appear on the cycle after start is sampled (1-cycle latency).
- RUN:
  - Drives table ctrl/data for step_idx; counter increments each cycle.
  - rsp_status[7]=1 -> ABORT with fault_code=1. Error wins over done and timeout when simultaneous.
  - Else rsp_status[0]=1 -> capture rsp_data into last_rsp, go to GAP.
  - Else counter reaching TIMEOUT_CYC-1 -> ABORT with fault_code=2.
  - pause=1 (and no error) -> cmd_ctrl=7, cmd_data unchanged, counter frozen, done ignored. Table ctrl resumes on the cycle after pause falls.
- GAP:
  - One cycle with cmd_ctrl=0, cmd_data=0; counter cleared.
  - If this was the last step: IDLE with done=1 for exactly that transition cycle and step_idx=0.
  - Else step_idx+1 and back to RUN. Pause and status are ignored in GAP.
- ABORT: one cycle with cmd_ctrl=6, cmd_data=0, then FAULT.
- FAULT:
  - cmd_ctrl=0; fault=1; fault_code held; start ignored.
  - clr_fault=1 -> IDLE, fault_code=0, step_idx=0.
- start is ignored while busy; prog_sel changes after latching have no effect.
- Asynchronous rst mid-program returns everything to reset values immediately; no STOP is issued.
- last_rsp retains its value across programs until the next step completion or rst.

Test Plan:
- Reset: rst high mid-RUN of prog 1 -> all outputs 0 in same cycle; cmd_ctrl=0.
- Normal run: prog_sel=0, start; actuator asserts status=01h 3 cycles into each step with rsp_data=step+A0h:
  - ctrl/data sequence is 1/40h, 0, 2/05h, 0, 3/00h, 0, 5/80h, 0.
  - done pulses once; last_rsp=A3h; step_idx ends at 0.
- Error: prog 2, status=80h during step 1 (WASH 1Eh):
  - next cycle ctrl=6 for one cycle, then fault=1, fault_code=1, ctrl=0.
  - clr_fault -> IDLE. Also status=81h in a single cycle -> fault_code=1, not done.
- Timeout: TIMEOUT_CYC=8, prog 3, status never done -> RINSE held 8 cycles, ctrl=6 one cycle, fault_code=2, busy=0.
- Pause: TIMEOUT_CYC=8, pause high 20 cycles during FILL step of prog 0:
  - ctrl=7, no timeout.
  - After release, FILL 40h resumes and times out only after 8 total unpaused cycles.
  - status=01h while paused does not advance.
- Start while busy: second start with prog_sel=2 during prog 0 -> ignored; sequence remains prog 0 (4 steps).

Source files
------------

// File: rtl/wm_cycle_sequencer.sv
// Wash cycle sequencer: walks a hard-wired wash program over the actuator
// command bus, holding each step until done, error or timeout.
module wm_cycle_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] prog_sel_i,
    input  logic       pause_i,
    input  logic       clr_fault_i,
    input  logic [7:0] rsp_data_i,
    input  logic [7:0] rsp_status_i,
    output logic [2:0] cmd_ctrl_o,
    output logic [7:0] cmd_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o,
    output logic [1:0] fault_code_o,
    output logic [2:0] step_idx_o,
    output logic [7:0] last_rsp_o
);

    localparam int unsigned CTRL_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned ENTRY_W = CTRL_W + DATA_W;

    localparam logic [CTRL_W-1:0] CTRL_NOP   = 3'd0;
    localparam logic [CTRL_W-1:0] CTRL_FILL  = 3'd1;
    localparam logic [CTRL_W-1:0] CTRL_WASH  = 3'd2;
    localparam logic [CTRL_W-1:0] CTRL_DRAIN = 3'd3;
    localparam logic [CTRL_W-1:0] CTRL_RINSE = 3'd4;
    localparam logic [CTRL_W-1:0] CTRL_SPIN  = 3'd5;
    localparam logic [CTRL_W-1:0] CTRL_STOP  = 3'd6;
    localparam logic [CTRL_W-1:0] CTRL_PAUSE = 3'd7;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_ERR  = 2'd1;
    localparam logic [1:0] FC_TO   = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_ABORT = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    // Program table lookup: {ctrl, data} for a given program and step.
    function automatic logic [ENTRY_W-1:0] step_entry(input logic [1:0] prog,
                                                      input logic [STEP_W-1:0] idx);
        logic [ENTRY_W-1:0] e;
        e = '0;
        case ({prog, idx})
            5'b00_000: e = {CTRL_FILL,  8'h40};
            5'b00_001: e = {CTRL_WASH,  8'h05};
            5'b00_010: e = {CTRL_DRAIN, 8'h00};
            5'b00_011: e = {CTRL_SPIN,  8'h80};
            5'b01_000: e = {CTRL_FILL,  8'h80};
            5'b01_001: e = {CTRL_WASH,  8'h0F};
            5'b01_010: e = {CTRL_DRAIN, 8'h00};
            5'b01_011: e = {CTRL_RINSE, 8'h80};
            5'b01_100: e = {CTRL_DRAIN, 8'h00};
            5'b01_101: e = {CTRL_SPIN,  8'hC0};
            5'b10_000: e = {CTRL_FILL,  8'hFF};
            5'b10_001: e = {CTRL_WASH,  8'h1E};
            5'b10_010: e = {CTRL_DRAIN, 8'h00};
            5'b10_011: e = {CTRL_RINSE, 8'hFF};
            5'b10_100: e = {CTRL_DRAIN, 8'h00};
            5'b10_101: e = {CTRL_SPIN,  8'hFF};
            5'b11_000: e = {CTRL_RINSE, 8'h80};
            5'b11_001: e = {CTRL_DRAIN, 8'h00};
            5'b11_010: e = {CTRL_SPIN,  8'hC0};
            default:   e = '0;
        endcase
        return e;
    endfunction

    // Index of the final step of each program.
    function automatic logic [STEP_W-1:0] last_step(input logic [1:0] prog);
        logic [STEP_W-1:0] l;
        case (prog)
            2'd0:    l = 3'd3;
            2'd1:    l = 3'd5;
            2'd2:    l = 3'd5;
            default: l = 3'd2;
        endcase
        return l;
    endfunction

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [1:0]          code_q, code_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic [1:0]          prog_q, prog_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;

    // Only done (bit0) and error (bit7) carry meaning on the status bus.
    logic unused_status;
    assign unused_status = ^rsp_status_i[6:1];

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= CTRL_NOP;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            step_q  <= '0;
            last_q  <= '0;
            prog_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            step_q  <= step_d;
            last_q  <= last_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fault_d = fault_q;
        code_d  = code_q;
        step_d  = step_q;
        last_d  = last_q;
        prog_d  = prog_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                ctrl_d = CTRL_NOP;
                data_d = '0;
                if (start_i) begin
                    state_d          = S_RUN;
                    prog_d           = prog_sel_i;
                    step_d           = '0;
                    cnt_d            = '0;
                    busy_d           = 1'b1;
                    {ctrl_d, data_d} = step_entry(prog_sel_i, '0);
                end
            end
            S_RUN: begin
                if (rsp_status_i[7]) begin
                    state_d = S_ABORT;
                    code_d  = FC_ERR;
                    ctrl_d  = CTRL_STOP;
                    data_d  = '0;
                    cnt_d   = '0;
                end else if (pause_i) begin
                    ctrl_d = CTRL_PAUSE;
                end else if (rsp_status_i[0]) begin
                    state_d = S_GAP;
                    last_d  = rsp_data_i;
                    ctrl_d  = CTRL_NOP;
                    data_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ABORT;
                    code_d  = FC_TO;
                    ctrl_d  = CTRL_STOP;
                    data_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d            = cnt_q + TO_W'(1);
                    {ctrl_d, data_d} = step_entry(prog_q, step_q);
                end
            end
            S_GAP: begin
                cnt_d = '0;
                if (step_q == last_step(prog_q)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    step_d  = '0;
                    ctrl_d  = CTRL_NOP;
                    data_d  = '0;
                end else begin
                    state_d          = S_RUN;
                    step_d           = step_q + 3'd1;
                    {ctrl_d, data_d} = step_entry(prog_q, step_q + 3'd1);
                end
            end
            S_ABORT: begin
                state_d = S_FAULT;
                busy_d  = 1'b0;
                fault_d = 1'b1;
                ctrl_d  = CTRL_NOP;
                data_d  = '0;
            end
            S_FAULT: begin
                ctrl_d = CTRL_NOP;
                data_d = '0;
                if (clr_fault_i) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ctrl_d  = CTRL_NOP;
                data_d  = '0;
                busy_d  = 1'b0;
                fault_d = 1'b0;
            end
        endcase
    end

    assign cmd_ctrl_o   = ctrl_q;
    assign cmd_data_o   = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign step_idx_o   = step_q;
    assign last_rsp_o   = last_q;

endmodule
